// File: rtl/pkg_alu_defs.sv
// Shared definitions for the pipelined ALU: opcode encoding, flag bundle
// and the default datapath width.
package pkg_alu_defs;

    localparam int ALU_DATA_SIZE = 8;

    typedef enum logic [7:0] {
        OP_ADD = 8'h00,
        OP_ADC = 8'h01,
        OP_SUB = 8'h02,
        OP_SBB = 8'h03,
        OP_AND = 8'h04,
        OP_OR  = 8'h05,
        OP_XOR = 8'h06,
        OP_NOT = 8'h07,
        OP_SHL = 8'h08,
        OP_SHR = 8'h09,
        OP_ROL = 8'h0A,
        OP_ROR = 8'h0B,
        OP_MUL = 8'h0C
    } alu_op_e;

    typedef struct packed {
        logic carry;
        logic zero;
        logic neg;
        logic aux_carry;
    } alu_flags_t;

endpackage

// File: rtl/alu_pipe_if.sv
// Operation/result handshake bundle for alu_pipe. The master side is the
// operation source plus result consumer; the slave side is the ALU itself.
interface alu_pipe_if #(
    parameter int DATA_SIZE = 8,
    parameter int TAG_W     = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [7:0]           in_op;
    logic [DATA_SIZE-1:0] in_oper_a;
    logic [DATA_SIZE-1:0] in_oper_b;
    logic                 in_flag_carry;
    logic                 in_flag_zero;
    logic                 in_flag_neg;
    logic                 in_flag_aux_carry;
    logic [TAG_W-1:0]     in_tag;

    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_SIZE-1:0] out_result;
    logic                 out_flag_carry;
    logic                 out_flag_zero;
    logic                 out_flag_neg;
    logic                 out_flag_aux_carry;
    logic [TAG_W-1:0]     out_tag;
    logic                 out_illegal;

    modport master (
        output in_valid, in_op, in_oper_a, in_oper_b,
               in_flag_carry, in_flag_zero, in_flag_neg, in_flag_aux_carry, in_tag,
               out_ready,
        input  in_ready,
               out_valid, out_result, out_flag_carry, out_flag_zero,
               out_flag_neg, out_flag_aux_carry, out_tag, out_illegal
    );

    modport slave (
        input  in_valid, in_op, in_oper_a, in_oper_b,
               in_flag_carry, in_flag_zero, in_flag_neg, in_flag_aux_carry, in_tag,
               out_ready,
        output in_ready,
               out_valid, out_result, out_flag_carry, out_flag_zero,
               out_flag_neg, out_flag_aux_carry, out_tag, out_illegal
    );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU datapath: one opcode, two operands and four flags in;
// result, four flags and an illegal-opcode indication out.
// Optional feature: define ALU_PIPE_MULT_EN to make opcode 0x0C (MUL) legal.
module alu_core
    import pkg_alu_defs::*;
#(
    parameter int DATA_SIZE = ALU_DATA_SIZE
) (
    input  logic [7:0]           op,
    input  logic [DATA_SIZE-1:0] a,
    input  logic [DATA_SIZE-1:0] b,
    input  alu_flags_t           flags_in,
    output logic [DATA_SIZE-1:0] result,
    output alu_flags_t           flags_out,
    output logic                 illegal
);
    localparam int W = DATA_SIZE;

    logic       cin;
    logic [W:0] add_full;
    logic [W:0] sub_full;
    logic [4:0] add_nib;
    logic [4:0] sub_nib;

    // Only ADC/SBB consume the incoming carry; ADD/SUB share the same adders.
    assign cin      = ((op == OP_ADC) || (op == OP_SBB)) ? flags_in.carry : 1'b0;
    // The extra top bit is carry-out for add and borrow for subtract.
    assign add_full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    assign sub_full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin};
    assign add_nib  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0000, cin};
    assign sub_nib  = {1'b0, a[3:0]} - {1'b0, b[3:0]} - {4'b0000, cin};

`ifdef ALU_PIPE_MULT_EN
    logic [2*W-1:0] prod;
    assign prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
`endif

    // Opcode decode; Z and N are derived from the result for every legal op.
    always_comb begin
        // NOTE: every output gets a default before the case so no path infers a latch.
        result    = a;
        flags_out = flags_in;
        illegal   = 1'b0;
        case (op)
            OP_ADD, OP_ADC: begin
                result              = add_full[W-1:0];
                flags_out.carry     = add_full[W];
                flags_out.aux_carry = add_nib[4];
            end
            OP_SUB, OP_SBB: begin
                result              = sub_full[W-1:0];
                flags_out.carry     = sub_full[W];
                flags_out.aux_carry = sub_nib[4];
            end
            OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                case (op)
                    OP_AND:  result = a & b;
                    OP_OR:   result = a | b;
                    OP_XOR:  result = a ^ b;
                    default: result = ~a;
                endcase
                flags_out.carry     = 1'b0;
                flags_out.aux_carry = 1'b0;
            end
            OP_SHL, OP_ROL: begin
                result              = {a[W-2:0], (op == OP_ROL) ? flags_in.carry : 1'b0};
                flags_out.carry     = a[W-1];
                flags_out.aux_carry = 1'b0;
            end
            OP_SHR, OP_ROR: begin
                result              = {(op == OP_ROR) ? flags_in.carry : 1'b0, a[W-1:1]};
                flags_out.carry     = a[0];
                flags_out.aux_carry = 1'b0;
            end
`ifdef ALU_PIPE_MULT_EN
            OP_MUL: begin
                result              = prod[W-1:0];
                flags_out.carry     = |prod[2*W-1:W];
                flags_out.aux_carry = 1'b0;
            end
`endif
            default: illegal = 1'b1;
        endcase
        if (!illegal) begin
            flags_out.zero = (result == '0);
            flags_out.neg  = result[W-1];
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU with valid/ready flow control and pass-through tags.
// Stage 0 registers the alu_core output; stages 1..STAGES-1 are pure delay,
// so an operation handshaken in cycle k is on the outputs in cycle k+STAGES.
// A single global stall freezes every stage while the consumer backpressures.
// Optional feature: define ALU_PIPE_MULT_EN to enable the MUL opcode.
module alu_pipe
    import pkg_alu_defs::*;
#(
    parameter int DATA_SIZE = ALU_DATA_SIZE,
    parameter int STAGES    = 2,
    parameter int TAG_W     = 4
) (
    input  logic      clock,
    input  logic      reset,
    alu_pipe_if.slave bus
);
    typedef struct packed {
        logic [DATA_SIZE-1:0] result;
        alu_flags_t           flags;
        logic [TAG_W-1:0]     tag;
        logic                 illegal;
    } stage_t;

    alu_flags_t           flags_in;
    logic [DATA_SIZE-1:0] core_result;
    alu_flags_t           core_flags;
    logic                 core_illegal;
    stage_t               core_stage;
    logic                 stall;
    logic                 accept;

    logic [STAGES-1:0]    valid_q;
    logic [STAGES-1:0]    valid_d;
    stage_t               data_q [STAGES];
    stage_t               data_d [STAGES];

    assign flags_in = '{carry:     bus.in_flag_carry,
                        zero:      bus.in_flag_zero,
                        neg:       bus.in_flag_neg,
                        aux_carry: bus.in_flag_aux_carry};

    alu_core #(
        .DATA_SIZE (DATA_SIZE)
    ) u_core (
        .op        (bus.in_op),
        .a         (bus.in_oper_a),
        .b         (bus.in_oper_b),
        .flags_in  (flags_in),
        .result    (core_result),
        .flags_out (core_flags),
        .illegal   (core_illegal)
    );

    assign core_stage = '{result:  core_result,
                          flags:   core_flags,
                          tag:     bus.in_tag,
                          illegal: core_illegal};

    // in_ready depends combinationally on out_ready through the stall term.
    assign stall        = valid_q[STAGES-1] && !bus.out_ready;
    assign bus.in_ready = !stall && !reset;
    assign accept       = bus.in_valid && bus.in_ready;

    // Advance every stage by one unless stalled; bubbles travel with zero payload.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (!stall) begin
            valid_d[0] = accept;
            data_d[0]  = accept ? core_stage : '0;
            for (int i = 1; i < STAGES; i++) begin
                valid_d[i] = valid_q[i-1];
                data_d[i]  = data_q[i-1];
            end
        end
    end

    // Stage registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            // NOTE: the payload array is reset too, because the output registers it feeds must read zero after reset.
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking so every stage samples its neighbour's pre-edge value.
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign bus.out_valid          = valid_q[STAGES-1];
    assign bus.out_result         = data_q[STAGES-1].result;
    assign bus.out_flag_carry     = data_q[STAGES-1].flags.carry;
    assign bus.out_flag_zero      = data_q[STAGES-1].flags.zero;
    assign bus.out_flag_neg       = data_q[STAGES-1].flags.neg;
    assign bus.out_flag_aux_carry = data_q[STAGES-1].flags.aux_carry;
    assign bus.out_tag            = data_q[STAGES-1].tag;
    assign bus.out_illegal        = data_q[STAGES-1].illegal;

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, pipelined ALU with valid/ready flow control, a configurable pipeline depth and pass-through transaction tags. It sits between an operation source, such as a decoder or testbench driver, and a result consumer. It executes one 8-bit-opcode operation per cycle on two DATA_SIZE operands and four input flags, and returns a result plus four output flags. It generalises the single-cycle ALU datapath with backpressure, in-order tagged results and illegal-opcode reporting.

## Interface
- DATA_SIZE, 8: operand/result width; must be ≥ 4.
- STAGES, 2: pipeline latency in cycles; must be ≥ 1.
- TAG_W, 4: width of the tag carried alongside each operation.
- clock  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  operation present.
- in_ready  out  1  block accepts the operation this cycle.
- in_op  in  8  opcode.
- in_oper_a, in_oper_b  in  DATA_SIZE  operands.
- in_flag_carry, in_flag_zero, in_flag_neg, in_flag_aux_carry  in  1 each  input flags.
- in_tag  in  TAG_W  opaque tag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_result  out  DATA_SIZE  result.
- out_flag_carry, out_flag_zero, out_flag_neg, out_flag_aux_carry  out  1 each  result flags.
- out_tag  out  TAG_W  tag of this result.
- out_illegal  out  1  opcode was not recognised.

## Operation
- Operations use unsigned arithmetic, with W = DATA_SIZE.
- Flag definitions:
  - Carry (C) is carry-out; for SUB/SBB it is the borrow, set when A < B (+cin).
  - Aux carry (AC) is the carry/borrow out of bit 3.
  - Z = (result == 0).
  - N = result[W-1].
- Arithmetic opcodes, computing C and AC:
  - 0x00 ADD: A+B.
  - 0x01 ADC: A+B+in_flag_carry.
  - 0x02 SUB: A−B.
  - 0x03 SBB: A−B−in_flag_carry.
- Logic opcodes, with C=0 and AC=0: 0x04 AND, 0x05 OR, 0x06 XOR, 0x07 NOT A.
- Shift opcodes, with AC=0:
  - 0x08 SHL: A<<1, C=A[W-1].
  - 0x09 SHR: A>>1, C=A[0].
  - 0x0A ROL: {A[W-2:0],cin}, C=A[W-1].
  - 0x0B ROR: {cin,A[W-1:1]}, C=A[0].
- Any other opcode: result=A, all four out flags = the input flags, out_illegal=1.
- Accept on in_valid && in_ready. Compute happens in the first stage; the remaining STAGES−1 stages are delay registers.
- Results are delivered strictly in acceptance order; the tag travels unchanged.
- Transfer on out_valid && out_ready.
- Global stall: stall = out_valid && !out_ready.
  - While stall is high, every stage holds.
  - in_ready = !stall && !reset. This is a combinational path from out_ready.
  - Bubbles are not collapsed.
- Reset drops all in-flight operations. All valid bits clear, and every output register goes to 0: out_valid, out_result, all out flags, out_tag, out_illegal.

## Timing
- Latency: an operation accepted at edge k presents out_valid after edge k+STAGES.
- Throughput: one operation per cycle when out_ready stays high.
- Simultaneous input accept and output transfer in one cycle are both legal and both occur.
- When out_valid=1 && out_ready=0, all outputs hold stable, including result, flags, tag and illegal, until the transfer.
- Reset asserted mid-stall: on the next edge, out_valid=0. While reset is high, in_ready=0.
- in_valid is ignored while in_ready=0. The source must hold the operation until it is accepted.

## Configuration
- ALU_PIPE_MULT_EN defined:
  - Opcode 0x0C MUL is legal: result = low W bits of A×B.
  - C=1 if the upper W bits of the product are nonzero. AC=0.
  - The multiply is in the compute stage; latency is unchanged.
- Not defined: 0x0C is illegal, with the standard illegal behaviour.

## Structure
- Shared package pkg_alu_defs holds:
  - alu_op_e, the opcode enum listing the values above, including MUL.
  - alu_flags_t, a packed struct {carry, zero, neg, aux_carry}.
  - DATA_SIZE default constant.
- Sub-module alu_core: purely combinational. Takes (op, a, b, flags in) and produces (result, flags out, illegal). The macro guards only its MUL branch. alu_pipe instantiates it and owns the stage registers and handshake.

## Test plan
All scenarios use DATA_SIZE=8, STAGES=3.
- ADD 0x0F+0x01, flags in 0 → 0x10, C=0, Z=0, N=0, AC=1; out_valid exactly 3 cycles after accept.
- ADD 0xFF+0x01 → 0x00, C=1, Z=1, N=0, AC=1. SUB 0x00−0x01 → 0xFF, C=1, N=1, AC=1.
- ROL 0x80 with cin=1 → 0x01, C=1. SBB 0x10−0x01 with cin=1 → 0x0E, C=0, AC=1.
- Opcode 0xFF, A=0x5A, flags in C=1/Z=0/N=1/AC=0 → result 0x5A, the same flags, out_illegal=1. With ALU_PIPE_MULT_EN, MUL 0x10×0x10 → 0x00, C=1, Z=1; without it, out_illegal=1.
- Backpressure:
  - Stimulus: 5 back-to-back ops with tags 0–4; out_ready held low for 4 cycles after the first out_valid.
  - Required: in_ready low throughout, outputs stable, then tags 0–4 delivered in order with no loss or duplication.
- Reset with 3 ops in flight → out_valid=0 the next cycle, all outputs 0, no stale result afterward. The first post-reset op arrives with latency 3.
